// File: rtl/control_pkg.sv
// Shared types and constants for the multicycle control unit.
package control_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    ClsIllegal = 3'd0,
    ClsR       = 3'd1,
    ClsAddi    = 3'd2,
    ClsLw      = 3'd3,
    ClsSw      = 3'd4,
    ClsBeq     = 3'd5
  } iclass_e;

  // Map opcode/funct fields onto the supported subset; anything else is illegal.
  function automatic iclass_e classify(input logic [6:0] opcode, input logic [2:0] funct3,
                                       input logic [6:0] funct7);
    iclass_e cls;
    cls = ClsIllegal;
    case (opcode)
      OP_R:   if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) cls = ClsR;
      OP_I:   if (funct3 == F3_ADD) cls = ClsAddi;
      OP_LW:  if (funct3 == F3_WORD) cls = ClsLw;
      OP_SW:  if (funct3 == F3_WORD) cls = ClsSw;
      OP_BEQ: if (funct3 == F3_BEQ) cls = ClsBeq;
      default: cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_unit_mc_if.sv
// Bus between the control unit and the fetch/datapath blocks.
interface control_unit_mc_if #(
  parameter int unsigned XLEN = 32
);
  logic            run;
  logic [XLEN-1:0] instr_in;
  logic            zero;
  logic [XLEN-1:0] ir;
  logic            pc_inc;
  logic            pc_load;
  logic            we_reg;
  logic            we_mem;
  logic            op_mem;
  logic            add_sub;
  logic            alu_src_imm;
  logic [XLEN-1:0] offset;
  logic [2:0]      state_o;
  logic            halted;
  logic            illegal;

  modport master (
    output run, instr_in, zero,
    input  ir, pc_inc, pc_load, we_reg, we_mem, op_mem, add_sub, alu_src_imm, offset,
           state_o, halted, illegal
  );

  modport slave (
    input  run, instr_in, zero,
    output ir, pc_inc, pc_load, we_reg, we_mem, op_mem, add_sub, alu_src_imm, offset,
           state_o, halted, illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended I/S/B immediates, zero for everything else.
module imm_gen
  import control_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_ir,
  output logic [XLEN-1:0] o_offset
);

  logic w_unused;
  assign w_unused = ^i_ir[19:12];

  // Select the immediate layout from the opcode.
  always_comb begin
    o_offset = '0;
    case (i_ir[6:0])
      OP_I, OP_LW: o_offset = {{(XLEN-12){i_ir[31]}}, i_ir[31:20]};
      OP_SW:       o_offset = {{(XLEN-12){i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      OP_BEQ:      o_offset = {{(XLEN-13){i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25],
                               i_ir[11:8], 1'b0};
      default:     o_offset = '0;
    endcase
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle Moore control unit for the RV32I add/sub/addi/lw/sw/beq subset.
module control_unit_mc
  import control_pkg::*;
#(
  parameter int unsigned XLEN            = XLEN_DEF,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input logic         clk,
  input logic         reset,
  control_unit_mc_if.slave bus
);

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_offset;
  logic [XLEN-1:0] w_imm;
  logic            r_illegal;
  iclass_e         w_cls;
  logic            w_rd_nz;

  // Class is always derived from the latched IR, never from instr_in.
  assign w_cls   = classify(r_ir[6:0], r_ir[14:12], r_ir[31:25]);
  assign w_rd_nz = |r_ir[11:7];

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .i_ir    (r_ir),
    .o_offset(w_imm)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StFetch;
    else       r_state <= w_state_next;
  end

  // IR latch in FETCH, offset load and sticky illegal flag in DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir      <= '0;
      r_offset  <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == StFetch && bus.run) r_ir <= bus.instr_in;
      if (r_state == StDecode) begin
        r_offset <= w_imm;
        if (w_cls == ClsIllegal) r_illegal <= 1'b1;
      end
    end
  end

  // Next-state logic; unused codes fall back to FETCH.
  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch:  w_state_next = bus.run ? StDecode : StFetch;
      StDecode: begin
        if (w_cls != ClsIllegal)  w_state_next = StExec;
        else if (HALT_ON_ILLEGAL) w_state_next = StHalt;
        else                      w_state_next = StFetch;
      end
      StExec: begin
        case (w_cls)
          ClsR, ClsAddi: w_state_next = StWb;
          ClsLw, ClsSw:  w_state_next = StMem;
          default:       w_state_next = StFetch;
        endcase
      end
      StMem:   w_state_next = (w_cls == ClsLw) ? StWb : StFetch;
      StWb:    w_state_next = StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  // Strobe decode from state and IR (zero only qualifies the beq branch).
  always_comb begin
    bus.pc_inc      = 1'b0;
    bus.pc_load     = 1'b0;
    bus.we_reg      = 1'b0;
    bus.we_mem      = 1'b0;
    bus.op_mem      = 1'b0;
    bus.add_sub     = 1'b0;
    bus.alu_src_imm = 1'b0;
    case (r_state)
      StDecode: begin
        if (w_cls == ClsIllegal && !HALT_ON_ILLEGAL) bus.pc_inc = 1'b1;
      end
      StExec: begin
        bus.add_sub     = (w_cls == ClsR && r_ir[31:25] == F7_SUB) || (w_cls == ClsBeq);
        bus.alu_src_imm = (w_cls == ClsAddi) || (w_cls == ClsLw) || (w_cls == ClsSw);
        if (w_cls == ClsBeq) begin
          bus.pc_load = bus.zero;
          bus.pc_inc  = ~bus.zero;
        end
      end
      StMem: begin
        bus.alu_src_imm = 1'b1;
        if (w_cls == ClsSw) begin
          bus.we_mem = 1'b1;
          bus.pc_inc = 1'b1;
        end
        if (w_cls == ClsLw) bus.op_mem = 1'b1;
      end
      StWb: begin
        bus.we_reg = w_rd_nz;
        bus.op_mem = (w_cls == ClsLw);
        bus.pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ir      = r_ir;
  assign bus.offset  = r_offset;
  assign bus.state_o = r_state;
  assign bus.halted  = (r_state == StHalt);
  assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: stimulus pushes expected per-cycle records,
// a negedge monitor pops one per non-FETCH cycle and compares.
module tb_control_unit_mc;

  typedef struct packed {
    logic [2:0]  st;
    logic [6:0]  sb;   // {pc_inc, pc_load, we_reg, we_mem, op_mem, add_sub, alu_src_imm}
    logic [31:0] off;
    logic [31:0] ir;
    logic        ill;
    logic        hlt;
  } rec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  rec_t exp_q[$];
  logic [31:0] off_prev;

  control_unit_mc_if #(.XLEN(32)) bus ();

  control_unit_mc dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] strobes();
    return {bus.pc_inc, bus.pc_load, bus.we_reg, bus.we_mem, bus.op_mem, bus.add_sub,
            bus.alu_src_imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [6:0] sb, input logic [31:0] off,
                      input logic [31:0] ir, input logic ill);
    rec_t r;
    r.st  = st;
    r.sb  = sb;
    r.off = off;
    r.ir  = ir;
    r.ill = ill;
    r.hlt = (st == 3'd5);
    exp_q.push_back(r);
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 in DECODE.
  task automatic launch(input logic [31:0] ins, input logic z);
    bus.instr_in = ins;
    bus.zero     = z;
    bus.run      = 1'b1;
    @(posedge clk); #1;
    bus.run      = 1'b0;
    bus.instr_in = 32'h1234_5678;
  endtask

  task automatic run_instr(input string nm, input logic [31:0] ins, input logic z,
                           input int lat);
    int n;
    launch(ins, z);
    n = 0;
    while (bus.state_o != 3'd0 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n + 1, lat);
  endtask

  // Monitor: compare each non-FETCH cycle against the scoreboard; FETCH must be quiet.
  always @(negedge clk) begin
    rec_t act;
    rec_t exp;
    if (!reset) begin
      if (bus.state_o == 3'd0) begin
        chk("fetch_quiet", {24'd0, bus.halted, strobes()}, 32'd0);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cycle actual_state=%0d expected=none", bus.state_o);
      end else begin
        exp     = exp_q.pop_front();
        act.st  = bus.state_o;
        act.sb  = strobes();
        act.off = bus.offset;
        act.ir  = bus.ir;
        act.ill = bus.illegal;
        act.hlt = bus.halted;
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL cycle_rec actual=st%0d sb%b off%h ir%h ill%b hlt%b required=st%0d sb%b off%h ir%h ill%b hlt%b",
                   act.st, act.sb, act.off, act.ir, act.ill, act.hlt,
                   exp.st, exp.sb, exp.off, exp.ir, exp.ill, exp.hlt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins;
    checks       = 0;
    failures     = 0;
    off_prev     = 32'd0;
    reset        = 1'b1;
    bus.run      = 1'b0;
    bus.instr_in = 32'd0;
    bus.zero     = 1'b0;

    #12;
    chk("rst_state", {29'd0, bus.state_o}, 32'd0);
    chk("rst_ir", bus.ir, 32'd0);
    chk("rst_offset", bus.offset, 32'd0);
    chk("rst_flags", {30'd0, bus.illegal, bus.halted}, 32'd0);
    chk("rst_strobes", {25'd0, strobes()}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // run=0 holds in FETCH
    repeat (3) @(posedge clk);
    #1;
    chk("idle_state", {29'd0, bus.state_o}, 32'd0);

    // add x3,x1,x2
    ins = 32'h002081B3;
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    push(3'd2, 7'b0000000, 32'd0, ins, 1'b0);
    push(3'd4, 7'b1010000, 32'd0, ins, 1'b0);
    off_prev = 32'd0;
    run_instr("add", ins, 1'b0, 4);

    // sub
    ins = 32'h402081B3;
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    push(3'd2, 7'b0000010, 32'd0, ins, 1'b0);
    push(3'd4, 7'b1010000, 32'd0, ins, 1'b0);
    off_prev = 32'd0;
    run_instr("sub", ins, 1'b0, 4);

    // lw x5,8(x0)
    ins = 32'h00802283;
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    push(3'd2, 7'b0000001, 32'd8, ins, 1'b0);
    push(3'd3, 7'b0000101, 32'd8, ins, 1'b0);
    push(3'd4, 7'b1010100, 32'd8, ins, 1'b0);
    off_prev = 32'd8;
    run_instr("lw", ins, 1'b0, 5);

    // sw x5,-4(x2)
    ins = 32'hFE512E23;
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    push(3'd2, 7'b0000001, 32'hFFFFFFFC, ins, 1'b0);
    push(3'd3, 7'b1001001, 32'hFFFFFFFC, ins, 1'b0);
    off_prev = 32'hFFFFFFFC;
    run_instr("sw", ins, 1'b0, 4);

    // beq taken
    ins = 32'hFE208CE3;
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    push(3'd2, 7'b0100010, 32'hFFFFFFF8, ins, 1'b0);
    off_prev = 32'hFFFFFFF8;
    run_instr("beq_t", ins, 1'b1, 3);

    // beq not taken
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    push(3'd2, 7'b1000010, 32'hFFFFFFF8, ins, 1'b0);
    run_instr("beq_nt", ins, 1'b0, 3);
    bus.zero = 1'b0;

    // addi x0,x0,1: rd=0 suppresses the write
    ins = 32'h00100013;
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    push(3'd2, 7'b0000001, 32'd1, ins, 1'b0);
    push(3'd4, 7'b1000000, 32'd1, ins, 1'b0);
    off_prev = 32'd1;
    run_instr("addi_x0", ins, 1'b0, 4);

    // completed instruction with run low stays in FETCH
    repeat (2) @(posedge clk);
    #1;
    chk("post_idle_state", {29'd0, bus.state_o}, 32'd0);

    // illegal -> HALT; run toggling has no effect
    ins = 32'hFFFFFFFF;
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    repeat (4) push(3'd5, 7'b0000000, 32'd0, ins, 1'b1);
    launch(ins, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      bus.run = ~bus.run;
    end
    @(posedge clk); #1;
    chk("halt_hold", {29'd0, bus.state_o}, 32'd5);
    reset   = 1'b1;
    bus.run = 1'b0;
    #1;
    chk("halt_rst_state", {29'd0, bus.state_o}, 32'd0);
    chk("halt_rst_flags", {30'd0, bus.illegal, bus.halted}, 32'd0);
    chk("halt_rst_ir", bus.ir, 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    off_prev = 32'd0;

    // reset during MEM of sw kills we_mem immediately
    ins = 32'hFE512E23;
    push(3'd1, 7'b0000000, off_prev, ins, 1'b0);
    push(3'd2, 7'b0000001, 32'hFFFFFFFC, ins, 1'b0);
    push(3'd3, 7'b1001001, 32'hFFFFFFFC, ins, 1'b0);
    launch(ins, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_strobes", {25'd0, strobes()}, 32'd0);
    chk("midrst_state", {29'd0, bus.state_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Multicycle control unit directly upstream of the PC/instruction-fetch block and the register-file/memory datapath.
- Latches the fetched instruction into an instruction register (IR).
- Sequences each instruction through a Moore FSM and drives the datapath strobes: PC increment/load, register write, memory write, memory-to-register select, add/subtract, and immediate offset.
- Supported subset: RV32I add, sub, addi, lw, sw, beq.

Parameters:
- XLEN, 32, datapath/instruction width.
- HALT_ON_ILLEGAL, 1, 1 = an illegal instruction enters HALT; 0 = skip it (PC increment, return to FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  permits a new fetch; sampled only in FETCH.
- instr_in  in  XLEN  instruction word from PC/instruction memory.
- zero  in  1  ALU result == 0, from the datapath; used by beq.
- ir  out  XLEN  instruction register; rs1=ir[19:15], rs2=ir[24:20], rd=ir[11:7].
- pc_inc  out  1  PC += 4, one-cycle pulse.
- pc_load  out  1  PC += offset, one-cycle pulse.
- we_reg  out  1  register-file write enable.
- we_mem  out  1  data-memory write enable.
- op_mem  out  1  1 = writeback data from memory, 0 = from ALU.
- add_sub  out  1  0 = add, 1 = subtract.
- alu_src_imm  out  1  ALU B operand: 1 = offset, 0 = rs2.
- offset  out  XLEN  sign-extended immediate, registered.
- state_o  out  3  current state code, for debug.
- halted  out  1  FSM is in HALT.
- illegal  out  1  sticky: an illegal instruction was decoded.

Behaviour:
- Reset (asynchronous):
  - state = FETCH; ir = 0; offset = 0; illegal = 0.
  - All strobes low; halted low.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6-7 are unreachable and recover to FETCH.
- Strobe outputs are decoded from the registered state and ir only (Moore). No combinational path from instr_in to any strobe.
- FETCH:
  - run=1: ir <= instr_in; go to DECODE.
  - run=0: hold; all strobes 0.
- DECODE:
  - Classify the opcode and load offset from the immediate generator.
  - Legal instruction: go to EXEC.
  - Illegal with HALT_ON_ILLEGAL=1: set illegal; go to HALT.
  - Illegal with HALT_ON_ILLEGAL=0: set illegal; pc_inc=1; go to FETCH.
- EXEC:
  - add_sub=1 for sub (funct7=0100000) and for beq; 0 otherwise.
  - alu_src_imm=1 for addi, lw, sw; 0 otherwise.
  - R-type/addi: go to WB.
  - lw/sw: go to MEM.
  - beq: zero=1 gives pc_load=1, else pc_inc=1; go to FETCH.
- MEM:
  - alu_src_imm=1; add_sub=0.
  - sw: we_mem=1, pc_inc=1; go to FETCH.
  - lw: op_mem=1; go to WB.
- WB:
  - we_reg=1 unless rd==0; then we_reg=0 for all writing instructions.
  - op_mem=1 for lw.
  - pc_inc=1; go to FETCH.
- HALT: all strobes 0; halted=1. Exits only through reset.
- Latency in cycles, FETCH to next FETCH: R/addi 4, lw 5, sw 4, beq 3.
- Mutual exclusion: pc_inc and pc_load are never high together. we_reg and we_mem are never high together.
- Immediate generation:
  - I-type: ir[31:20].
  - S-type: {ir[31:25], ir[11:7]}.
  - B-type: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - R-type: offset = 0.
  - All sign-extended to XLEN.
- Legal instruction set (anything else is illegal):
  - opcode 0110011 with funct3=000 and funct7 in {0000000, 0100000}.
  - opcode 0010011 with funct3=000.
  - opcode 0000011 or 0100011 with funct3=010.
  - opcode 1100011 with funct3=000.
- run deasserted mid-instruction: the instruction completes; the FSM then waits in FETCH.
- Reset mid-instruction: state returns to FETCH immediately. No strobe may persist after reset asserts.
- ir and offset hold their values from DECODE until the next FETCH latch.

Decomposition:
- Shared package control_pkg:
  - state enum and its codes.
  - opcode constants OP_R, OP_I, OP_LW, OP_SW, OP_BEQ.
  - funct3/funct7 constants.
  - XLEN default.
- One combinational sub-module imm_gen: (ir) -> offset, sign-extended.

Test Plan:
- Reset, run=1, instr_in=0x002081B3 (add x3,x1,x2) -> we_reg=1 and pc_inc=1 together in cycle 4 only; add_sub=0; alu_src_imm=0.
- instr_in=0x402081B3 (sub) -> add_sub=1 in EXEC; we_reg=1 in WB.
- instr_in=0x00802283 (lw x5,8(x0)) -> offset=8; MEM in cycle 4; WB in cycle 5 with op_mem=1 and we_reg=1.
- instr_in=0xFE512E23 (sw x5,-4(x2)) -> offset=0xFFFFFFFC; we_mem=1 and pc_inc=1 in cycle 4; we_reg never high.
- instr_in=0xFE208CE3 (beq, -8) -> offset=0xFFFFFFF8; zero=1 gives pc_load=1 in cycle 3; zero=0 gives pc_inc=1; 3-cycle latency.
- instr_in=0x00100013 (addi x0,x0,1) -> we_reg stays 0, pc_inc=1 in WB.
- instr_in=0xFFFFFFFF -> HALT, illegal=1, halted=1; run toggling has no effect; reset returns to FETCH.
- Reset asserted during MEM of a sw -> we_mem drops immediately.
